// File: rtl/scope_pkg.sv
// Shared constants and FSM encoding for the scope acquisition path and its renderer.
package scope_pkg;

  localparam int unsigned SAMPLE_W_DEF = 8;
  localparam int unsigned DEPTH_DEF    = 640;
  localparam int unsigned ADDR_W_DEF   = 10;

  typedef enum logic [1:0] {
    StWaitTrig = 2'd0,
    StCapture  = 2'd1,
    StDone     = 2'd2
  } state_e;

endpackage

// File: rtl/scope_dpram.sv
// Two-bank simple dual-port RAM: one write port, one registered read port.
// Address is {bank, addr}; bank 1 is folded onto words DEPTH..2*DEPTH-1 so the
// array holds exactly 2*DEPTH words and maps onto block RAM.
module scope_dpram #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned DEPTH    = 640,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                clock,
  input  logic                wr_en,
  input  logic [ADDR_W:0]     wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W:0]     rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  localparam int unsigned Words = 2 * DEPTH;

  logic [SAMPLE_W-1:0] mem [Words];

  function automatic logic [ADDR_W:0] lin_addr(input logic [ADDR_W:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a[ADDR_W-1:0]};
    return a[ADDR_W] ? off + (ADDR_W + 1)'(DEPTH) : off;
  endfunction

  // Synchronous write and registered read; no reset so the array stays in block RAM.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[lin_addr(wr_addr)] <= wr_data;
    end
    rd_data <= mem[lin_addr(rd_addr)];
  end

endmodule

// File: rtl/scope_capture.sv
// Scope acquisition: decimate, detect a level-crossing trigger, capture one record
// into the back bank and hand it to the display side only at a frame boundary.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DECIM_W  = 16,
  parameter int unsigned AUTO_TO  = 2048
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  input  logic [DECIM_W-1:0]  decim,
  input  logic                run,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                front_valid,
  output logic                trig_pulse,
  output logic                auto_flag,
  output logic [1:0]          state
);

  localparam int unsigned TO_W = (AUTO_TO > 1) ? $clog2(AUTO_TO) : 1;

  state_e              state_q;
  logic [DECIM_W-1:0]  dcnt_q;
  logic [SAMPLE_W-1:0] prev_q;
  logic                prev_valid_q;
  logic [TO_W-1:0]     tcnt_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [SAMPLE_W-1:0] wr_data_q;
  logic                front_sel_q;
  logic                front_valid_q;
  logic                trig_pulse_q;
  logic                auto_flag_q;
  logic                auto_pend_q;
  logic                rd_zero_q;

  logic                accept;
  logic                trig_hit;
  logic                timeout;
  logic                rd_in_range;
  logic [SAMPLE_W-1:0] ram_q;

  assign accept      = sample_valid && (dcnt_q == '0);
  assign timeout     = (tcnt_q == TO_W'(AUTO_TO - 1));
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));

  // Level-crossing compare of the accepted sample against the previous accepted one.
  always_comb begin
    trig_hit = 1'b0;
    if (prev_valid_q) begin
      if (trig_rising) begin
        trig_hit = (prev_q < trig_level) && (sample_in >= trig_level);
      end else begin
        trig_hit = (prev_q >= trig_level) && (sample_in < trig_level);
      end
    end
  end

  // Decimation counter: keep one of every decim+1 valid samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      dcnt_q <= '0;
    end else if (sample_valid) begin
      dcnt_q <= (dcnt_q == '0) ? decim : dcnt_q - 1'b1;
    end
  end

  // Capture FSM; the RAM write request is registered so trig_pulse coincides with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StWaitTrig;
      prev_q        <= '0;
      prev_valid_q  <= 1'b0;
      tcnt_q        <= '0;
      wr_ptr_q      <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      front_sel_q   <= 1'b0;
      front_valid_q <= 1'b0;
      trig_pulse_q  <= 1'b0;
      auto_flag_q   <= 1'b0;
      auto_pend_q   <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      trig_pulse_q <= 1'b0;
      case (state_q)
        StWaitTrig: begin
          if (accept) begin
            prev_q       <= sample_in;
            prev_valid_q <= 1'b1;
            tcnt_q       <= tcnt_q + 1'b1;
            if (trig_hit || timeout) begin
              wr_en_q      <= 1'b1;
              wr_addr_q    <= '0;
              wr_data_q    <= sample_in;
              trig_pulse_q <= 1'b1;
              // A real crossing on the timeout sample still counts as a trigger.
              auto_pend_q  <= !trig_hit;
              wr_ptr_q     <= ADDR_W'(1);
              state_q      <= StCapture;
            end
          end
        end
        StCapture: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= wr_ptr_q;
            wr_data_q <= sample_in;
            wr_ptr_q  <= wr_ptr_q + 1'b1;
            if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          if (frame_start && run) begin
            front_sel_q   <= ~front_sel_q;
            front_valid_q <= 1'b1;
            auto_flag_q   <= auto_pend_q;
            prev_valid_q  <= 1'b0;
            tcnt_q        <= '0;
            state_q       <= StWaitTrig;
          end
        end
        default: state_q <= StWaitTrig;
      endcase
    end
  end

  // Zero-gating for reads, aligned with the RAM's one-cycle read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_zero_q <= 1'b1;
    end else begin
      rd_zero_q <= !front_valid_q || !rd_in_range;
    end
  end

  // Out-of-range reads are steered to word 0 of the front bank; the result is gated anyway.
  scope_dpram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en_q),
    .wr_addr ({~front_sel_q, wr_addr_q}),
    .wr_data (wr_data_q),
    .rd_addr ({front_sel_q, rd_in_range ? rd_addr : ADDR_W'(0)}),
    .rd_data (ram_q)
  );

  assign rd_data     = rd_zero_q ? '0 : ram_q;
  assign front_valid = front_valid_q;
  assign trig_pulse  = trig_pulse_q;
  assign auto_flag   = auto_flag_q;
  assign state       = state_q;

endmodule

// File: doc/scope_capture.md
Name: scope_capture

Overview:
- Acquisition stage that feeds the VGA scope renderer.
- Decimates an incoming sample stream and detects a level-crossing trigger.
- Captures one screen-width record (DEPTH samples) into a double-buffered RAM.
- Swaps the fresh record to the display side only at a frame boundary, so the renderer never shows a torn trace.

Parameters:
SAMPLE_W, 8, sample and trigger-level width
DEPTH, 640, samples per record (one per visible pixel column)
ADDR_W, 10, record address width, 2^ADDR_W >= DEPTH
DECIM_W, 16, decimation ratio width
AUTO_TO, 2048, accepted samples without a trigger before forced (auto) capture

Ports:
clock  in  1  system clock; only clock
reset  in  1  synchronous, active-high reset
sample_valid  in  1  sample_in valid this cycle
sample_in  in  SAMPLE_W  unsigned sample
trig_level  in  SAMPLE_W  unsigned trigger threshold
trig_rising  in  1  1 = rising-edge trigger, 0 = falling
decim  in  DECIM_W  keep 1 of every decim+1 valid samples
run  in  1  1 = allow bank swaps; 0 = freeze displayed record
frame_start  in  1  single-cycle pulse at start of VGA vertical blanking
rd_addr  in  ADDR_W  renderer column address
rd_data  out  SAMPLE_W  front-bank sample, 1-cycle read latency
front_valid  out  1  front bank holds a complete record
trig_pulse  out  1  1-cycle pulse when a capture starts
auto_flag  out  1  last swapped record was auto-triggered
state  out  2  FSM state, for debug LEDs

Behaviour:
- Reset values: FSM = WAIT_TRIG, front_sel = 0, front_valid = 0, rd_data = 0, trig_pulse = 0, auto_flag = 0, decim counter = 0, prev_valid = 0. RAM contents are not reset.
- Decimation:
  - The counter advances only on sample_valid.
  - A sample is accepted when counter == 0. The counter then reloads to decim; otherwise it decrements.
  - decim = 0 accepts every valid sample.
- Trigger compare is on accepted samples only, cur against prev:
  - Rising trigger: prev < level && cur >= level.
  - Falling trigger: prev >= level && cur < level.
  - No trigger is possible while prev_valid = 0, i.e. on the first accepted sample after entering WAIT_TRIG.
- FSM encoding: WAIT_TRIG = 0, CAPTURE = 1, DONE = 2.
- WAIT_TRIG:
  - Each accepted sample updates prev and increments the timeout counter.
  - On trigger, or when the timeout counter reaches AUTO_TO-1:
    - write cur to back bank address 0;
    - pulse trig_pulse in the same cycle as the write;
    - latch auto_flag_pending (1 only for a timeout);
    - move to CAPTURE with wr_addr = 1.
  - If a trigger and the timeout occur on the same sample, the trigger wins and auto_flag_pending = 0.
- CAPTURE:
  - Each accepted sample is written to back bank address wr_addr, then wr_addr increments.
  - The write at DEPTH-1 moves the FSM to DONE.
  - Exactly DEPTH samples are written per record.
- DONE:
  - Accepted samples are discarded.
  - On frame_start with run = 1, all in the same cycle:
    - front_sel toggles;
    - front_valid goes to 1;
    - auto_flag takes auto_flag_pending;
    - the FSM returns to WAIT_TRIG with prev_valid = 0 and the timeout counter = 0.
  - frame_start with run = 0: stay in DONE; the display keeps the old record.
  - frame_start in WAIT_TRIG or CAPTURE is ignored.
- Read path:
  - rd_data is registered one cycle after rd_addr, from bank front_sel.
  - rd_data = 0 if rd_addr >= DEPTH or front_valid = 0.
  - A swap takes effect on reads issued in the cycle after the swap.
- Writes always target bank ~front_sel, so the renderer never reads the bank being written.
- A reset during CAPTURE or DONE abandons the record; front_valid returns to 0.

Decomposition:
- Package scope_pkg: FSM state encoding (WAIT_TRIG/CAPTURE/DONE), default SAMPLE_W/DEPTH/ADDR_W constants shared with the renderer.
- One sub-module, scope_dpram:
  - simple dual-port RAM, 2*DEPTH x SAMPLE_W;
  - one write port, one registered read port;
  - address {bank, addr};
  - infers DE1-SoC M10K.

Test Plan:
- Rising trigger: decim = 0, level = 128, ramp 0..255 step 1, wrapping. Required:
  - trig_pulse on the sample value 128;
  - after the next frame_start, rd_addr k returns (128+k) mod 256 for k = 0..639;
  - front_valid = 1, auto_flag = 0.
- Falling trigger plus decimation: trig_rising = 0, decim = 3, level = 100, descending ramp 255..0 step 1, wrapping. Required:
  - only every 4th valid sample is stored;
  - record[0] = the first accepted value < 100 whose preceding accepted value was >= 100;
  - consecutive stored entries differ by 4 (mod 256).
- Auto trigger: constant input 50, level 128. Required:
  - trig_pulse on accepted sample number AUTO_TO (2048);
  - after the swap, auto_flag = 1 and all 640 entries read 50.
- Freeze and frame gating:
  - Capture completes with run = 0 and two frame_start pulses follow. Required: no swap, front_valid stays 0, rd_data = 0.
  - Set run = 1; at the next frame_start the swap occurs and reads return the new record.
  - frame_start pulses during CAPTURE change nothing.
- Reset mid-capture: assert reset with wr_addr = 300. Required:
  - next cycle state = 0, front_valid = 0, rd_data = 0;
  - a subsequent full capture works normally.
- Read bounds and latency: rd_addr = 639 returns stored data one cycle later; rd_addr = 700 returns 0.
